// File: rtl/config_pkg.sv
// config_pkg: shared definitions for the serial configuration loader.
//   - state_t           : loader FSM states
//   - TILE_FRAME_W      : bits per logic-tile frame (LUT[31:0] + registered-output select)
//   - SBOX_FRAME_W      : bits per switch-box frame
//   - HDR_W             : width of the sync word and of both count fields
//   - DEFAULT_SYNC_WORD : stream header the loader expects unless overridden
package config_pkg;

  localparam int TILE_FRAME_W = 33;
  localparam int SBOX_FRAME_W = 16;
  localparam int HDR_W        = 8;

  localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hA5;

  typedef enum logic [3:0] {
    IDLE,
    SYNC,
    TCOUNT,
    TFRAME,
    TPAR,
    SCOUNT,
    SFRAME,
    SPAR,
    DONE,
    ERROR
  } state_t;

  // True while a load is in progress (everything except the three rest states).
  function automatic logic is_loading(state_t s);
    return !(s inside {IDLE, DONE, ERROR});
  endfunction

endpackage

// File: rtl/serial_field_rx.sv
// serial_field_rx: LSB-first deserialiser for one field of run-time width.
// Ports:
//   clock, reset_n  : clock and synchronous active-low reset
//   clear           : synchronous clear of shift register, bit counter and parity
//   shift_en        : consume bit_in on this posedge
//   bit_in          : serial data bit
//   field_w         : length of the current field in bits (1..MAX_W)
//   keep_parity     : carry the running parity across the end of this field
//   value           : field contents including the bit being shifted this cycle
//   field_done      : this posedge consumes the last bit of the field
//   parity_ok       : running parity XOR bit_in is even (meaningful on a 1-bit parity field)
module serial_field_rx #(
  parameter int MAX_W = 33
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic [5:0]       field_w,
  input  logic             keep_parity,
  output logic [MAX_W-1:0] value,
  output logic             field_done,
  output logic             parity_ok
);

  logic [MAX_W-1:0] sreg;
  logic [5:0]       bit_cnt;
  logic             run_par;

  // Bits above bit_cnt are always zero, so OR-ing in the new bit at its final
  // position yields the complete field on the cycle the last bit arrives.
  assign value      = sreg | (MAX_W'(bit_in) << bit_cnt);
  assign field_done = shift_en && (bit_cnt == field_w - 6'd1);
  assign parity_ok  = ~(run_par ^ bit_in);

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      sreg    <= '0;
      bit_cnt <= '0;
      run_par <= 1'b0;
    end else if (shift_en) begin
      if (field_done) begin
        // Counter wraps at the field length; the shift register restarts empty.
        sreg    <= '0;
        bit_cnt <= '0;
        run_par <= keep_parity ? (run_par ^ bit_in) : 1'b0;
      end else begin
        sreg    <= value;
        bit_cnt <= bit_cnt + 6'd1;
        run_par <= run_par ^ bit_in;
      end
    end
  end

endmodule

// File: rtl/config_loader.sv
// config_loader: receives a framed serial bitstream and writes tile and
// switch-box configuration frames onto the fabric configuration bus.
// Stream: SYNC(8) TCNT(8) TCNT x {tile(33) par(1)} SCNT(8) SCNT x {sbox(16) par(1)},
// every field LSB first, parity even over frame + parity bit.
// Ports:
//   clock, reset_n : clock and synchronous active-low reset
//   start          : one-cycle pulse, arms a load from IDLE/DONE/ERROR only
//   serial_input   : bitstream data
//   serial_valid   : qualifier; a bit is consumed on each posedge where it is 1.
//                    There is no ready: the loader accepts every valid bit while
//                    loading (including on a write-strobe cycle) and discards
//                    valid bits while idle, done or in error.
//   cfg_addr       : frame index of the last write (held until the next write)
//   cfg_data       : payload of the last write; switch-box writes zero [32:16]
//   tile_we        : one-cycle tile write strobe, the cycle after its parity bit
//   sbox_we        : one-cycle switch-box write strobe, the cycle after its parity bit
//   busy/done/error: status levels decoded from the FSM state
module config_loader
  import config_pkg::*;
#(
  parameter int         MAX_TILES = 16,
  parameter int         MAX_SBOX  = 16,
  parameter logic [7:0] SYNC_WORD = DEFAULT_SYNC_WORD
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        serial_input,
  input  logic        serial_valid,
  output logic [7:0]  cfg_addr,
  output logic [32:0] cfg_data,
  output logic        tile_we,
  output logic        sbox_we,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [7:0] MAX_T8 = 8'(MAX_TILES);
  localparam logic [7:0] MAX_S8 = 8'(MAX_SBOX);
  localparam logic [5:0] W_HDR  = 6'(HDR_W);
  localparam logic [5:0] W_TILE = 6'(TILE_FRAME_W);
  localparam logic [5:0] W_SBOX = 6'(SBOX_FRAME_W);

  state_t state, state_next;

  logic [7:0]  count;
  logic [7:0]  idx;
  logic [32:0] frame;

  logic [5:0]  field_w;
  logic        keep_parity;
  logic        rx_shift;
  logic        rx_clear;
  logic [32:0] rx_value;
  logic        field_done;
  logic        parity_ok;

  logic        load_count;
  logic        load_frame;
  logic        idx_clear;
  logic        idx_inc;
  logic        wr_tile;
  logic        wr_sbox;

  serial_field_rx #(
    .MAX_W (TILE_FRAME_W)
  ) u_rx (
    .clock       (clock),
    .reset_n     (reset_n),
    .clear       (rx_clear),
    .shift_en    (rx_shift),
    .bit_in      (serial_input),
    .field_w     (field_w),
    .keep_parity (keep_parity),
    .value       (rx_value),
    .field_done  (field_done),
    .parity_ok   (parity_ok)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next  = state;
    field_w     = W_HDR;
    keep_parity = 1'b0;
    rx_shift    = 1'b0;
    rx_clear    = 1'b0;
    load_count  = 1'b0;
    load_frame  = 1'b0;
    idx_clear   = 1'b0;
    idx_inc     = 1'b0;
    wr_tile     = 1'b0;
    wr_sbox     = 1'b0;
    busy        = is_loading(state);
    done        = (state == DONE);
    error       = (state == ERROR);

    case (state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_next = SYNC;
          rx_clear   = 1'b1;
          idx_clear  = 1'b1;
        end
      end
      SYNC: begin
        rx_shift = serial_valid;
        if (field_done) state_next = (rx_value[7:0] == SYNC_WORD) ? TCOUNT : ERROR;
      end
      TCOUNT: begin
        rx_shift = serial_valid;
        if (field_done) begin
          load_count = 1'b1;
          idx_clear  = 1'b1;
          if (rx_value[7:0] > MAX_T8)       state_next = ERROR;
          else if (rx_value[7:0] == 8'd0)   state_next = SCOUNT;
          else                              state_next = TFRAME;
        end
      end
      TFRAME: begin
        field_w     = W_TILE;
        keep_parity = 1'b1;
        rx_shift    = serial_valid;
        if (field_done) begin
          load_frame = 1'b1;
          state_next = TPAR;
        end
      end
      TPAR: begin
        field_w  = 6'd1;
        rx_shift = serial_valid;
        if (field_done) begin
          if (parity_ok) begin
            wr_tile    = 1'b1;
            idx_inc    = 1'b1;
            state_next = ((idx + 8'd1) < count) ? TFRAME : SCOUNT;
          end else begin
            state_next = ERROR;
          end
        end
      end
      SCOUNT: begin
        rx_shift = serial_valid;
        if (field_done) begin
          load_count = 1'b1;
          idx_clear  = 1'b1;
          if (rx_value[7:0] > MAX_S8)       state_next = ERROR;
          else if (rx_value[7:0] == 8'd0)   state_next = DONE;
          else                              state_next = SFRAME;
        end
      end
      SFRAME: begin
        field_w     = W_SBOX;
        keep_parity = 1'b1;
        rx_shift    = serial_valid;
        if (field_done) begin
          load_frame = 1'b1;
          state_next = SPAR;
        end
      end
      SPAR: begin
        field_w  = 6'd1;
        rx_shift = serial_valid;
        if (field_done) begin
          if (parity_ok) begin
            wr_sbox    = 1'b1;
            idx_inc    = 1'b1;
            state_next = ((idx + 8'd1) < count) ? SFRAME : DONE;
          end else begin
            state_next = ERROR;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count    <= '0;
      idx      <= '0;
      frame    <= '0;
      cfg_addr <= '0;
      cfg_data <= '0;
      tile_we  <= 1'b0;
      sbox_we  <= 1'b0;
    end else begin
      tile_we <= wr_tile;
      sbox_we <= wr_sbox;
      if (load_count) count <= rx_value[7:0];
      if (load_frame) frame <= (state == SFRAME) ? {17'b0, rx_value[15:0]} : rx_value;
      if (idx_clear)    idx <= '0;
      else if (idx_inc) idx <= idx + 8'd1;
      // Address and payload are registered with the strobe and then held.
      if (wr_tile || wr_sbox) begin
        cfg_addr <= idx;
        cfg_data <= frame;
      end
    end
  end

endmodule

// File: doc/config_loader.md
Name: config_loader

Overview:
- Serial bitstream configuration writer for the fabric.
- Receives a framed serial bitstream and writes it into the configuration registers of the logic tiles and switch boxes.
- Each logic tile takes 33 bits: LUT bits [31:0] and a registered-output select in bit [32].
- Each switch box takes 16 bits of `configure`.
- Sits between the external programming pin and the fabric's configuration write bus.

Parameters:
- MAX_TILES, 16, highest legal tile count; valid tile addresses are 0..MAX_TILES-1.
- MAX_SBOX, 16, highest legal switch-box count.
- SYNC_WORD, 8'hA5, required stream header.

Ports:
- clock  input  1  system clock; all logic acts on its posedge.
- reset_n  input  1  synchronous reset, active-low.
- start  input  1  one-cycle pulse; arms the loader, legal only from IDLE/DONE/ERROR.
- serial_input  input  1  bitstream data bit.
- serial_valid  input  1  serial_input is sampled on this cycle.
- cfg_addr  output  8  target tile or switch-box index.
- cfg_data  output  33  frame payload; switch-box frames use [15:0] with [32:16]=0.
- tile_we  output  1  one-cycle write strobe to tile `mem`.
- sbox_we  output  1  one-cycle write strobe to switch-box `configure`.
- busy  output  1  high from start until DONE or ERROR.
- done  output  1  level, high in DONE.
- error  output  1  level, high in ERROR.

Behaviour:
- Reset (reset_n=0 at posedge) puts the block in IDLE.
  - All outputs go to 0, all counters and the shift register clear.
  - Reset has priority over everything, including mid-frame; a partial frame is discarded with no write.
- A bit is consumed only on a posedge with serial_valid=1; with serial_valid=0 the state holds.
- All fields are sent LSB first: the first bit of each field lands in bit 0.
- Stream format:
  - SYNC (8 bits)
  - TCNT (8 bits)
  - TCNT × (33-bit tile frame + 1 parity bit)
  - SCNT (8 bits)
  - SCNT × (16-bit sbox frame + 1 parity bit)
- Parity is even over frame bits plus the parity bit.
- States: IDLE, SYNC, TCOUNT, TFRAME, TPAR, SCOUNT, SFRAME, SPAR, DONE, ERROR.
- IDLE/DONE/ERROR --start--> SYNC.
  - Clears done and error, sets busy, zeroes the bit counter and frame index.
- SYNC: after 8 bits, compare against SYNC_WORD. Mismatch → ERROR; match → TCOUNT.
- TCOUNT: after 8 bits:
  - TCNT > MAX_TILES → ERROR.
  - TCNT = 0 → SCOUNT.
  - Otherwise → TFRAME.
- TFRAME: collect 33 bits, then → TPAR.
- TPAR: check the parity bit.
  - Pass: on the next posedge, tile_we=1 for exactly one cycle with cfg_addr = frame index (0,1,2,…) and cfg_data = frame. Then increment the index; → TFRAME if index < TCNT, else → SCOUNT.
  - Fail: no write, → ERROR.
- SCOUNT, SFRAME and SPAR mirror TCOUNT, TFRAME and TPAR, using MAX_SBOX, 16-bit frames and sbox_we.
  - The frame index restarts at 0.
  - After the last sbox write, or if SCNT = 0, → DONE.
- Write latency: the strobe is asserted on the cycle after the parity bit is sampled.
  - A serial_valid bit arriving on the strobe cycle is accepted as the next frame's bit 0.
  - cfg_addr and cfg_data hold until the next write.
- DONE and ERROR: busy=0 and serial bits are ignored until start or reset.
- A start pulse while busy is ignored; the current load continues.
- Counter widths: the bit counter is 6 bits and wraps at the field length. The frame index is 8 bits.

Decomposition:
- Shared package `config_pkg` holds:
  - the state enum;
  - constants TILE_FRAME_W=33, SBOX_FRAME_W=16, HDR_W=8;
  - SYNC_WORD default.
- One sub-module, `serial_field_rx`:
  - a width-generic LSB-first shift register with bit counter and running parity;
  - outputs field_done and parity_ok;
  - reused for the header, count and frame fields.

Test Plan:
- Reset and minimal stream:
  - Stimulus: reset_n=0 for 2 cycles, then start, then A5, TCNT=0, SCNT=0.
  - Response: no strobes; done=1 and busy=0 after the 24th bit.
- One tile and one switch box:
  - Stimulus: TCNT=1 with frame 33'h1_8000_0001, SCNT=1 with frame 16'h8421, correct parity on both.
  - Response: tile_we one cycle with addr 0 and data 33'h1_8000_0001; then sbox_we one cycle with addr 0 and data 16'h8421; done=1.
- Bad sync:
  - Stimulus: header 8'h5A.
  - Response: error=1 and busy=0 after bit 8; no strobes; a later start recovers.
- Parity fault:
  - Stimulus: TCNT=2, second tile frame with parity bit flipped.
  - Response: tile_we only for addr 0; error=1; no sbox_we.
- Count overflow and gapped stream:
  - Stimulus 1: TCNT=17 with MAX_TILES=16 → error immediately after the count field.
  - Stimulus 2: a valid load with serial_valid toggling 1/0 every cycle → identical writes to the gap-free run.
- Reset mid-frame:
  - Stimulus: reset_n=0 in bit 20 of tile frame 1.
  - Response: all outputs 0 on the next cycle; no write for frame 1; a fresh start-and-load succeeds.
